// File: rtl/serial_parity_checker.sv
// Serial parity checker: deserializes DATA_W bits LSB-first and checks a trailing parity bit.
// Optional FRAME_TIMEOUT_EN aborts a frame after TIMEOUT_CYC idle cycles.
module serial_parity_checker #(
    parameter int DATA_W      = 8,
    parameter bit ODD_PARITY  = 1'b0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_calc,
    output logic              parity_err,
    output logic              frame_valid,
    output logic              timeout
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              acc;

`ifdef FRAME_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              in_frame;

    assign in_frame = (state == S_DATA) || (state == S_PARITY);
`else
    assign timeout = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            acc         <= ODD_PARITY;
            data_out    <= '0;
            parity_calc <= 1'b0;
            parity_err  <= 1'b0;
            frame_valid <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            idle_cnt    <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_DATA;
                        cnt   <= '0;
                        shreg <= '0;
                        acc   <= ODD_PARITY;
                    end
                end
                S_DATA: begin
                    if (bit_valid) begin
                        // MSB-in right shift leaves the first bit at bit 0
                        shreg <= {bit_in, shreg[DATA_W-1:1]};
                        acc   <= acc ^ bit_in;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == LAST_BIT) begin
                            state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_valid) begin
                        data_out    <= shreg;
                        parity_calc <= acc;
                        parity_err  <= acc ^ bit_in;
                        frame_valid <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
`ifdef FRAME_TIMEOUT_EN
            timeout <= 1'b0;
            if (state == S_IDLE && start) begin
                idle_cnt <= '0;
            end else if (in_frame) begin
                if (bit_valid) begin
                    idle_cnt <= '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    // abort overrides the case above; outputs keep last frame
                    idle_cnt <= '0;
                    state    <= S_IDLE;
                    timeout  <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Serial frame stage that sits downstream of the XOR gate. It accumulates a running XOR over DATA_W serially received data bits and compares the result against a trailing parity bit. It delivers the deserialized word, the computed parity and an error flag with a one-cycle frame_valid pulse. It is the sequential consumer of single-bit XOR results in the parity/checksum path.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
ODD_PARITY, 0, 0 = even parity, 1 = odd parity (initial accumulator value)
TIMEOUT_CYC, 16, idle-cycle limit inside a frame; used only when FRAME_TIMEOUT_EN is defined

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  begin new frame; honoured only in IDLE
bit_in  input  1  serial data/parity bit, LSB-first
bit_valid  input  1  bit_in qualifier; one bit accepted per cycle when high
busy  output  1  high in DATA, PARITY, DONE
data_out  output  DATA_W  last completed word, bit 0 = first bit received
parity_calc  output  1  expected parity bit of last frame
parity_err  output  1  received parity != parity_calc for last frame
frame_valid  output  1  one-cycle pulse: outputs above updated this cycle
timeout  output  1  one-cycle abort pulse (always 0 without FRAME_TIMEOUT_EN)

Behaviour:
- Reset, sampled on clk while rst_n=0: state=IDLE. busy, data_out, parity_calc, parity_err, frame_valid and timeout all go to 0. The shift register and bit counter clear. The accumulator loads ODD_PARITY.
- FSM states are IDLE, DATA, PARITY and DONE.
- IDLE: bit_valid is ignored. When start=1, go to DATA, clear the counter and shift register, and load acc=ODD_PARITY. busy rises on the next cycle.
- DATA: each cycle with bit_valid=1:
  - shift reg is right-shifted with bit_in entering the MSB, so after DATA_W bits the first bit sits at bit 0;
  - acc ^= bit_in;
  - cnt++.
  - When the bit accepted is number DATA_W (cnt==DATA_W-1), go to PARITY.
  - Gaps (bit_valid=0) are legal and hold all state.
- PARITY: the first bit_valid=1 cycle captures the parity bit. err_next = acc ^ bit_in. Go to DONE.
- DONE: lasts exactly one cycle.
  - data_out, parity_calc(=acc) and parity_err update registered in this cycle.
  - frame_valid=1.
  - Next state is IDLE.
  - Latency: frame_valid is high in the cycle after the parity bit is accepted.
- start outside IDLE is ignored, including a start held high through DONE. A new frame needs start sampled in IDLE, so the minimum inter-frame spacing is 1 idle cycle.
- bit_valid in DONE or IDLE is ignored, with no buffering.
- data_out, parity_calc and parity_err hold their values until the next frame_valid. They do not clear at frame start.
- Reset mid-frame: the partial frame is discarded, frame_valid is not raised, and the outputs return to reset values.
- DATA_W counter width: $clog2(DATA_W)+1. There is no wrap-around; the counter clears on start.

Optional Feature:
FRAME_TIMEOUT_EN
- When defined: an idle counter runs in DATA/PARITY.
  - It increments on each cycle with bit_valid=0 and clears on any bit_valid=1.
  - When it reaches TIMEOUT_CYC, the frame aborts: state=IDLE and timeout pulses 1 for one cycle.
  - frame_valid is not raised, and data_out/parity_* hold their old values.
  - The idle counter is reset by rst_n and on start.
- When undefined: no idle counter exists, timeout is tied to 0, and a frame waits indefinitely.

Test Plan:
1. DATA_W=8, ODD_PARITY=0. Pulse start, then send 0xA5 LSB-first (1,0,1,0,0,1,0,1) followed by parity 0 -> one cycle after the parity bit: frame_valid=1, data_out=0xA5, parity_calc=0, parity_err=0.
2. Same frame with parity bit 1 -> data_out=0xA5, parity_calc=0, parity_err=1. frame_valid is high for exactly 1 cycle, then busy=0.
3. ODD_PARITY=1. Send 0x00 with parity 1 -> parity_calc=1, parity_err=0. Next, send 0x01 with parity 1 -> parity_calc=0, parity_err=1.
4. Send 0x3C with 3-cycle bit_valid gaps between bits, start held high throughout, and bit_valid pulsed in IDLE beforehand -> data_out=0x3C, parity_err=0 with parity 0. Only one frame_valid occurs.
5. Drive rst_n=0 for 1 cycle after 4 of the 8 bits -> no frame_valid, all outputs 0, state IDLE. A following full frame 0xFF with parity 0 -> data_out=0xFF, parity_err=0.
6. With FRAME_TIMEOUT_EN and TIMEOUT_CYC=16: stop bit_valid after 3 bits -> timeout pulses on the 16th idle cycle, no frame_valid, data_out keeps its prior value, and busy=0 on the next cycle.
